// File: rtl/sdram_fb_writer.sv
// Streams one frame of 8-bit pixel indices into SDRAM, one word per pixel.
// Optional frame checksum enabled by defining FB_WRITER_CHECKSUM_EN.
module sdram_fb_writer #(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FB_WORDS = 76800
) (
  input  logic              sdram_clk,
  input  logic              reset,
  input  logic              done,
  input  logic              start,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       checksum
);

  localparam int unsigned       PIX_W     = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               pix_ready_q, pix_ready_d;
  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic start_ok;
  logic accept;

  assign start_ok = (state_q == S_IDLE) && start && done;
  assign accept   = (state_q == S_WRITE) && done && !waitrequest;

  // State and datapath registers
  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
    end
  end

  // Next state; losing done aborts the frame from any busy state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD;
          addr_d  = '0;
        end
      end
      S_LOAD: begin
        if (!done) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (pix_valid) begin
          pix_d   = pix_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!done) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (accept) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    pix_ready_d  = 1'b0;
    write_d      = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_d)
      S_IDLE:   ;
      S_LOAD:   begin pix_ready_d = 1'b1; busy_d = 1'b1; end
      S_WRITE:  begin write_d = 1'b1; busy_d = 1'b1; end
      S_FINISH: begin frame_done_d = 1'b1; busy_d = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      pix_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_ready_q  <= pix_ready_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign write      = write_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign address    = addr_q;
  assign writedata  = DATA_W'(pix_q);

`ifdef FB_WRITER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running sum of accepted words, restarted with each accepted frame request
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + 16'(pix_q);
    end
  end

  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_fb_writer.sv
// Randomized self-checking bench for sdram_fb_writer with a pixel/write scoreboard.
module tb_sdram_fb_writer;

  localparam int unsigned AW  = 25;
  localparam int unsigned DW  = 16;
  localparam int unsigned FBW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          done;
  logic          start;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic          busy;
  logic          frame_done;
  logic [15:0]   checksum;

  int n_chk  = 0;
  int n_fail = 0;

  sdram_fb_writer #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .FB_WORDS (FBW)
  ) dut (
    .sdram_clk   (clk),
    .reset       (reset),
    .done        (done),
    .start       (start),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .busy        (busy),
    .frame_done  (frame_done),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef FB_WRITER_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  // One frame: random handshakes, every accepted write checked against the pixel queue
  task automatic run_frame(input int unsigned vpct, input int unsigned wpct,
                           input bit spam, input bit fixed, output int cyc);
    logic [7:0]    exp_q[$];
    int            words  = 0;
    int            pushes = 0;
    logic [15:0]   sum    = 16'h0;
    bit            fd     = 1'b0;
    bit            stalled = 1'b0;
    bit            idle_ld = 1'b0;
    logic [AW-1:0] sa = '0;
    logic [DW-1:0] sd = '0;
    @(negedge clk);
    done = 1'b1; start = 1'b1; pix_valid = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_addr", 32'(address), 32'(0));
    while (cyc < 4000) begin
      if (frame_done) begin
        fd = 1'b1;
        break;
      end
      if (stalled) begin
        chk("stall_write", 32'(write), 32'(1));
        chk("stall_addr", 32'(address), 32'(sa));
        chk("stall_data", 32'(writedata), 32'(sd));
        chk("stall_rdy", 32'(pix_ready), 32'(0));
      end
      if (idle_ld) begin
        chk("load_rdy", 32'(pix_ready), 32'(1));
        chk("load_write", 32'(write), 32'(0));
        chk("load_addr", 32'(address), 32'(sa));
      end
      chk("rdy_wr_excl", 32'(pix_ready & write), 32'(0));
      stalled = 1'b0;
      idle_ld = 1'b0;
      pix_valid   = ($urandom_range(99) < vpct);
      pix_data    = fixed ? 8'((pushes + 1) * 17) : 8'($urandom);
      waitrequest = ($urandom_range(99) < wpct);
      start       = spam && ($urandom_range(7) == 0);
      if (pix_ready && pix_valid) begin
        exp_q.push_back(pix_data);
        pushes++;
      end
      if (pix_ready && !pix_valid) begin
        idle_ld = 1'b1;
        sa = address;
      end
      if (write) begin
        if (waitrequest) begin
          stalled = 1'b1;
          sa = address;
          sd = writedata;
        end else begin
          chk("wr_addr", 32'(address), 32'(words));
          if (exp_q.size() == 0) begin
            chk("wr_nopix", 32'(1), 32'(0));
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("wr_data", 32'(writedata), 32'({8'h00, e}));
            sum += 16'(e);
          end
          words++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; pix_valid = 1'b0; waitrequest = 1'b0;
    chk("frame_done_seen", 32'(fd), 32'(1));
    chk("words", 32'(words), 32'(FBW));
    chk("checksum", 32'(checksum), 32'(exp_sum(sum)));
    @(negedge clk);
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_fd", 32'(frame_done), 32'(0));
    chk("post_addr", 32'(address), 32'(0));
    chk("post_cs", 32'(checksum), 32'(exp_sum(sum)));
  endtask

  initial begin
    int  cyc;
    bit  hit;
    reset = 1'b1; done = 1'b0; start = 1'b0; pix_data = 8'h00;
    pix_valid = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_write", 32'(write), 32'(0));
    chk("rst_rdy", 32'(pix_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_fd", 32'(frame_done), 32'(0));
    chk("rst_addr", 32'(address), 32'(0));
    chk("rst_data", 32'(writedata), 32'(0));
    chk("rst_cs", 32'(checksum), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Start while SDRAM not initialised is ignored
    done = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; done = 1'b1;
    chk("nodone_busy", 32'(busy), 32'(0));
    chk("nodone_rdy", 32'(pix_ready), 32'(0));
    @(negedge clk);
    chk("nodone_busy2", 32'(busy), 32'(0));

    // Zero-stall frame with known pixels
    run_frame(100, 0, 1'b0, 1'b1, cyc);
    chk("frame_len", 32'(cyc), 32'(2 * FBW));

    for (int i = 0; i < 8; i++) begin
      run_frame(30 + 10 * i, 8 * i, 1'b1, 1'b0, cyc);
    end

    // Abort by dropping done at address 1
    @(negedge clk);
    done = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b1; waitrequest = 1'b0; pix_data = 8'h5a;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (address == AW'(1) && pix_ready) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach", 32'(hit), 32'(1));
    done = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_addr", 32'(address), 32'(0));
    chk("abort_write", 32'(write), 32'(0));
    chk("abort_rdy", 32'(pix_ready), 32'(0));
    chk("abort_fd", 32'(frame_done), 32'(0));
    done = 1'b1; pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet_fd", 32'(frame_done), 32'(0));
      chk("abort_quiet_wr", 32'(write), 32'(0));
    end
    run_frame(70, 30, 1'b1, 1'b0, cyc);

    // Asynchronous reset during a stalled write
    @(negedge clk);
    done = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b1; waitrequest = 1'b1; pix_data = 8'hc3;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (write) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_wr", 32'(hit), 32'(1));
    #1 reset = 1'b1;
    #1;
    chk("arst_write", 32'(write), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_rdy", 32'(pix_ready), 32'(0));
    chk("arst_addr", 32'(address), 32'(0));
    chk("arst_data", 32'(writedata), 32'(0));
    chk("arst_cs", 32'(checksum), 32'(0));
    chk("arst_fd", 32'(frame_done), 32'(0));
    @(negedge clk);
    reset = 1'b0; pix_valid = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_wr", 32'(write), 32'(0));
      chk("post_rst_busy", 32'(busy), 32'(0));
      chk("post_rst_fd", 32'(frame_done), 32'(0));
    end
    run_frame(100, 0, 1'b1, 1'b1, cyc);
    chk("frame_len2", 32'(cyc), 32'(2 * FBW));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
